mod_sigma_seq: RTL

- Parametrised, sequential successor to the 32-bit XOR block.
- Computes Y = B ^ T0 ^ T1 ^ T2, where each term Tk is X rotated right or shifted right by a per-term amount, and each term can be enabled individually.
- Covers SHA-256 Σ0/Σ1/σ0/σ1, plain A^B and SHA-512 (WIDTH=64) with one unit.
- Iterative, one term per clock, with valid/ready handshakes on both sides; sits between the message-schedule and compression datapaths.

---
 rtl/mod_sha_pkg.sv | 28 ++
 rtl/mod_sigma_seq_if.sv | 28 ++
 rtl/mod_rotshr.sv | 22 ++
 rtl/mod_sigma_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mod_sha_pkg.sv
// Shared types and SHA-2 sigma constant sets for the sequential sigma unit.
package mod_sha_pkg;

   typedef enum logic [2:0] {IDLE, T0, T1, T2, HOLD} state_t;

   localparam logic KIND_ROT = 1'b1;
   localparam logic KIND_SHR = 1'b0;

   // One sigma function: three amounts, per-term kind (bit 0 = term 0) and enables.
   typedef struct packed {
      logic [7:0] sh0;
      logic [7:0] sh1;
      logic [7:0] sh2;
      logic [0:2] kind;
      logic [0:2] en;
   } sigma_cfg_t;

   localparam sigma_cfg_t SHA256_SUM0 = '{sh0: 8'd2,  sh1: 8'd13, sh2: 8'd22, kind: 3'b111, en: 3'b111};
   localparam sigma_cfg_t SHA256_SUM1 = '{sh0: 8'd6,  sh1: 8'd11, sh2: 8'd25, kind: 3'b111, en: 3'b111};
   localparam sigma_cfg_t SHA256_SIG0 = '{sh0: 8'd7,  sh1: 8'd18, sh2: 8'd3,  kind: 3'b110, en: 3'b111};
   localparam sigma_cfg_t SHA256_SIG1 = '{sh0: 8'd17, sh1: 8'd19, sh2: 8'd10, kind: 3'b110, en: 3'b111};

   localparam sigma_cfg_t SHA512_SUM0 = '{sh0: 8'd28, sh1: 8'd34, sh2: 8'd39, kind: 3'b111, en: 3'b111};
   localparam sigma_cfg_t SHA512_SUM1 = '{sh0: 8'd14, sh1: 8'd18, sh2: 8'd41, kind: 3'b111, en: 3'b111};
   localparam sigma_cfg_t SHA512_SIG0 = '{sh0: 8'd1,  sh1: 8'd8,  sh2: 8'd7,  kind: 3'b110, en: 3'b111};
   localparam sigma_cfg_t SHA512_SIG1 = '{sh0: 8'd19, sh1: 8'd61, sh2: 8'd6,  kind: 3'b110, en: 3'b111};

endpackage

// File: rtl/mod_sigma_seq_if.sv
// Request/response bundle of the sigma unit; bit 0 of each word is the MSB.
interface mod_sigma_seq_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
   logic [0:WIDTH-1]   X;
   logic [0:WIDTH-1]   B;
   logic [SHAMT_W-1:0] SH0;
   logic [SHAMT_W-1:0] SH1;
   logic [SHAMT_W-1:0] SH2;
   logic [0:2]         KIND;
   logic [0:2]         EN;
   logic               IN_VALID;
   logic               IN_READY;
   logic [0:WIDTH-1]   Y;
   logic               OUT_VALID;
   logic               OUT_READY;

   modport master (
      output X, B, SH0, SH1, SH2, KIND, EN, IN_VALID, OUT_READY,
      input  IN_READY, Y, OUT_VALID
   );

   modport slave (
      input  X, B, SH0, SH1, SH2, KIND, EN, IN_VALID, OUT_READY,
      output IN_READY, Y, OUT_VALID
   );
endinterface

// File: rtl/mod_rotshr.sv
// Combinational barrel rotate-right / logical shift-right; amount 0 passes x through.
module mod_rotshr
   import mod_sha_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic [0:WIDTH-1]   x,
   input  logic [SHAMT_W-1:0] amt,
   input  logic               kind,
   output logic [0:WIDTH-1]   z_c
);
   logic [SHAMT_W:0]   inv_amt;
   logic [0:WIDTH-1]   shr_c;

   // Rotate = shift plus the wrapped-around low bits; a left shift by WIDTH yields 0.
   always_comb begin
      inv_amt = (SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(amt);
      shr_c   = x >> amt;
      z_c     = (kind == KIND_ROT) ? (shr_c | (x << inv_amt)) : shr_c;
   end
endmodule

// File: rtl/mod_sigma_seq.sv
// Iterative Y = B ^ T0 ^ T1 ^ T2 unit: one rotate/shift term per clock through a shared barrel.
module mod_sigma_seq
   import mod_sha_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input logic           CLK,
   input logic           RST,
   mod_sigma_seq_if.slave bus
);
   state_t             state_q, state_n;
   logic [0:WIDTH-1]   x_q, acc_q, acc_n, y_q, y_n;
   logic [SHAMT_W-1:0] sh0_q, sh1_q, sh2_q;
   logic [0:2]         kind_q, en_q;
   logic               in_ready_q, in_ready_n, out_valid_q, out_valid_n;
   logic               load_c;
   logic [SHAMT_W-1:0] amt_c;
   logic               kind_c, en_c;
   logic [0:WIDTH-1]   z_c, term_c;

   mod_rotshr #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_rotshr (
      .x    (x_q),
      .amt  (amt_c),
      .kind (kind_c),
      .z_c  (z_c)
   );

   // Select the current term's controls for the shared barrel.
   always_comb begin
      amt_c  = sh0_q;
      kind_c = kind_q[0];
      en_c   = en_q[0];
      case (state_q)
         T1: begin
            amt_c  = sh1_q;
            kind_c = kind_q[1];
            en_c   = en_q[1];
         end
         T2: begin
            amt_c  = sh2_q;
            kind_c = kind_q[2];
            en_c   = en_q[2];
         end
         default: ;
      endcase
      term_c = en_c ? z_c : '0;
   end

   always_comb begin
      state_n = state_q;
      acc_n   = acc_q;
      y_n     = y_q;
      load_c  = 1'b0;
      case (state_q)
         IDLE: if (bus.IN_VALID) begin
            load_c  = 1'b1;
            acc_n   = bus.B;
            state_n = T0;
         end
         T0: begin
            acc_n   = acc_q ^ term_c;
            state_n = T1;
         end
         T1: begin
            acc_n   = acc_q ^ term_c;
            state_n = T2;
         end
         T2: begin
            acc_n   = acc_q ^ term_c;
            y_n     = acc_q ^ term_c;
            state_n = HOLD;
         end
         HOLD: if (bus.OUT_READY) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Handshake flags track the state being entered so they are registered yet current.
      in_ready_n  = (state_n == IDLE);
      out_valid_n = (state_n == HOLD);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         acc_q       <= acc_n;
         y_q         <= y_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
      end
   end

   // Request operands are captured only at the accept edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         x_q    <= '0;
         sh0_q  <= '0;
         sh1_q  <= '0;
         sh2_q  <= '0;
         kind_q <= '0;
         en_q   <= '0;
      end else if (load_c) begin
         x_q    <= bus.X;
         sh0_q  <= bus.SH0;
         sh1_q  <= bus.SH1;
         sh2_q  <= bus.SH2;
         kind_q <= bus.KIND;
         en_q   <= bus.EN;
      end
   end

   assign bus.IN_READY  = in_ready_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.Y         = y_q;
endmodule
